// File: rtl/fir_mc_pkg.sv
// fir_mc_pkg: shared constants for the time-multiplexed FIR engine.
// FSM encodings and width helpers used by the top and its datapath.
package fir_mc_pkg;

  localparam logic [2:0] S_CLR  = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_MAC  = 3'd2;
  localparam logic [2:0] S_RND  = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  function automatic int ptrw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int accw(input int dw, input int cw, input int taps);
    return dw + cw + ptrw(taps);
  endfunction

endpackage

// File: rtl/fir_mac_dp.sv
// fir_mac_dp: signed multiply-accumulate with round, shift and saturate.
// One product per cycle while en; the output register loads only on fin.
module fir_mac_dp import fir_mc_pkg::*; #(
  parameter int DW     = 16,
  parameter int CW     = 16,
  parameter int TAPS   = 64,
  parameter int OSHIFT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          fin,
  input  logic [DW-1:0] x,
  input  logic [CW-1:0] h,
  output logic [DW-1:0] dout,
  output logic          sat
);

  localparam int ACCW = accw(DW, CW, TAPS);
  localparam int AW1  = ACCW + 1;
  localparam int PW   = DW + CW;
  localparam int RS   = (OSHIFT > 0) ? OSHIFT - 1 : 0;

  localparam logic signed [ACCW:0] RND =
    (OSHIFT > 0) ? (AW1'(1) << RS) : '0;
  localparam logic signed [ACCW:0] MAXV = AW1'(2 ** (DW - 1) - 1);
  localparam logic signed [ACCW:0] MINV = AW1'(-(2 ** (DW - 1)));

  logic signed [ACCW-1:0] acc;
  logic signed [PW-1:0]   prod;
  logic signed [ACCW:0]   rsum;
  logic signed [ACCW:0]   shf;

  assign prod = $signed(x) * $signed(h);
  // one guard bit keeps the rounding add from wrapping
  assign rsum = AW1'(acc) + RND;
  assign shf  = rsum >>> OSHIFT;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      dout <= '0;
      sat  <= 1'b0;
    end else begin
      if (clr) begin
        acc <= '0;
      end else if (en) begin
        acc <= acc + ACCW'(prod);
      end
      if (fin) begin
        if (shf > MAXV) begin
          dout <= {1'b0, {(DW-1){1'b1}}};
          sat  <= 1'b1;
        end else if (shf < MINV) begin
          dout <= {1'b1, {(DW-1){1'b0}}};
          sat  <= 1'b1;
        end else begin
          dout <= shf[DW-1:0];
          sat  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/fir_mc_tdm.sv
// fir_mc_tdm: one MAC engine shared by NCH channels, each with its own
// TAPS-deep delay line, plus double-buffered coefficient banks.
module fir_mc_tdm import fir_mc_pkg::*; #(
  parameter int DW     = 16,
  parameter int CW     = 16,
  parameter int TAPS   = 64,
  parameter int NCH    = 2,
  parameter int OSHIFT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DW-1:0]         din,
  input  logic [ptrw(NCH)-1:0]  din_ch,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic                  cload,
  input  logic [ptrw(TAPS)-1:0] caddr,
  input  logic [CW-1:0]         cin,
  input  logic                  cswap,
  output logic                  bank_sel,
  output logic [DW-1:0]         dout,
  output logic [ptrw(NCH)-1:0]  dout_ch,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  sat
);

  localparam int CHW   = ptrw(NCH);
  localparam int KW    = ptrw(TAPS);
  localparam int DEPTH = NCH * TAPS;
  localparam int AW    = ptrw(DEPTH);

  logic [2:0]     state;
  logic [AW-1:0]  clr_cnt;
  logic [KW-1:0]  k;
  logic [CHW-1:0] ch;
  logic [KW-1:0]  wptr [NCH];
  logic           swap_pending;

  logic [DW-1:0] dline [DEPTH];
  logic [CW-1:0] bank0 [TAPS];
  logic [CW-1:0] bank1 [TAPS];

  logic          take;
  logic          give;
  logic          busy;
  logic [KW-1:0] rd_off;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] x;
  logic [CW-1:0] h;

  assign take       = (state == S_IDLE) && din_valid;
  assign give       = (state == S_OUT) && dout_ready;
  assign busy       = (state == S_MAC) || (state == S_RND)
                   || (state == S_OUT);
  assign din_ready  = state == S_IDLE;
  assign dout_valid = state == S_OUT;
  assign dout_ch    = ch;

  // tap k reads x[n-k]: walk backwards from the newest sample
  assign rd_off  = wptr[ch] - k;
  assign rd_addr = AW'({ch, rd_off});
  assign wr_addr = AW'({din_ch, wptr[din_ch]});
  assign x       = dline[rd_addr];
  assign h       = bank_sel ? bank1[k] : bank0[k];

  always_ff @(posedge clk) begin
    if (state == S_CLR) begin
      dline[clr_cnt] <= '0;
    end else if (take) begin
      dline[wr_addr] <= din;
    end
  end

  // loads always target the shadow bank
  always_ff @(posedge clk) begin
    if (cload && bank_sel) begin
      bank0[caddr] <= cin;
    end
    if (cload && !bank_sel) begin
      bank1[caddr] <= cin;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_CLR;
      clr_cnt      <= '0;
      k            <= '0;
      ch           <= '0;
      bank_sel     <= 1'b0;
      swap_pending <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        wptr[i] <= '0;
      end
    end else begin
      case (state)
        S_CLR: begin
          clr_cnt <= clr_cnt + AW'(1);
          if (clr_cnt == AW'(DEPTH - 1)) begin
            state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (din_valid) begin
            ch    <= din_ch;
            k     <= '0;
            state <= S_MAC;
          end
        end
        S_MAC: begin
          k <= k + KW'(1);
          if (k == KW'(TAPS - 1)) begin
            state <= S_RND;
          end
        end
        S_RND: state <= S_OUT;
        S_OUT: begin
          if (dout_ready) begin
            wptr[ch] <= wptr[ch] + KW'(1);
            state    <= S_IDLE;
          end
        end
        default: state <= S_CLR;
      endcase

      // a result in flight keeps its bank until it is accepted
      if (!busy) begin
        if (cswap) begin
          bank_sel <= ~bank_sel;
        end
      end else if (give) begin
        if (cswap || swap_pending) begin
          bank_sel <= ~bank_sel;
        end
        swap_pending <= 1'b0;
      end else if (cswap) begin
        swap_pending <= 1'b1;
      end
    end
  end

  fir_mac_dp #(
    .DW     (DW),
    .CW     (CW),
    .TAPS   (TAPS),
    .OSHIFT (OSHIFT)
  ) u_dp (
    .clk  (clk),
    .rst  (rst),
    .clr  (take),
    .en   (state == S_MAC),
    .fin  (state == S_RND),
    .x    (x),
    .h    (h),
    .dout (dout),
    .sat  (sat)
  );

endmodule

// File: tb/tb_fir_mc_tdm.sv
// tb_fir_mc_tdm: randomized and directed checks of fir_mc_tdm against
// a sum-of-products reference kept in plain arrays and queues.
module tb_fir_mc_tdm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din = '0;
  logic        din_ch = 1'b0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic        cload = 1'b0;
  logic [5:0]  caddr = '0;
  logic [15:0] cin = '0;
  logic        cswap = 1'b0;
  logic        bank_sel;
  logic [15:0] dout;
  logic        dout_ch;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic        sat;

  logic [15:0] b_din = '0;
  logic        b_din_ch = 1'b0;
  logic        b_din_valid = 1'b0;
  logic        b_din_ready;
  logic        b_cload = 1'b0;
  logic [2:0]  b_caddr = '0;
  logic [15:0] b_cin = '0;
  logic        b_cswap = 1'b0;
  logic        b_bank_sel;
  logic [15:0] b_dout;
  logic        b_dout_ch;
  logic        b_dout_valid;
  logic        b_dout_ready = 1'b0;
  logic        b_sat;

  int checks = 0;
  int errors = 0;

  int cm [2][64];
  bit m_bsel = 1'b0;
  int hist [2][$];
  int c2 [8];
  int hist2 [2][$];

  always #5 clk = ~clk;

  fir_mc_tdm #(
    .DW(16), .CW(16), .TAPS(64), .NCH(2), .OSHIFT(0)
  ) dut (
    .clk(clk), .rst(rst),
    .din(din), .din_ch(din_ch),
    .din_valid(din_valid), .din_ready(din_ready),
    .cload(cload), .caddr(caddr), .cin(cin),
    .cswap(cswap), .bank_sel(bank_sel),
    .dout(dout), .dout_ch(dout_ch),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .sat(sat)
  );

  fir_mc_tdm #(
    .DW(16), .CW(16), .TAPS(8), .NCH(2), .OSHIFT(15)
  ) dut2 (
    .clk(clk), .rst(rst),
    .din(b_din), .din_ch(b_din_ch),
    .din_valid(b_din_valid), .din_ready(b_din_ready),
    .cload(b_cload), .caddr(b_caddr), .cin(b_cin),
    .cswap(b_cswap), .bank_sel(b_bank_sel),
    .dout(b_dout), .dout_ch(b_dout_ch),
    .dout_valid(b_dout_valid), .dout_ready(b_dout_ready),
    .sat(b_sat)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint fir_sum(input int c);
    longint s = 0;
    int n = hist[c].size();
    for (int j = 0; j < 64; j++) begin
      if (j < n) s += longint'(hist[c][n-1-j]) * longint'(cm[m_bsel][j]);
    end
    return s;
  endfunction

  function automatic int clip(input longint y, input int sh, output bit s);
    longint d, q;
    q = y;
    if (sh > 0) begin
      d = longint'(1) << sh;
      q = y + d / 2;
      q = (q >= 0) ? q / d : -((-q + d - 1) / d);
    end
    s = (q > 32767) || (q < -32768);
    if (q > 32767) return 32767;
    if (q < -32768) return -32768;
    return int'(q);
  endfunction

  function automatic void model_reset();
    m_bsel = 1'b0;
    hist[0].delete();
    hist[1].delete();
    hist2[0].delete();
    hist2[1].delete();
  endfunction

  task automatic load_shadow(input int v, input bit ramp);
    int val;
    for (int j = 0; j < 64; j++) begin
      val = ramp ? j + 1 : v;
      cload = 1'b1;
      caddr = 6'(j);
      cin = 16'(val);
      cm[m_bsel ? 0 : 1][j] = val;
      step();
    end
    cload = 1'b0;
  endtask

  task automatic swap_idle();
    cswap = 1'b1;
    step();
    cswap = 1'b0;
    m_bsel = !m_bsel;
  endtask

  task automatic send(input int c, input int xv, input int swap_at,
                      input int hold, output int got, output int gch,
                      output bit gsat, output int lat, output bit bpre,
                      output bit stable);
    int n;
    logic [15:0] d0;
    n = 0;
    while (din_ready !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    din = 16'(xv);
    din_ch = c[0];
    din_valid = 1'b1;
    dout_ready = 1'b0;
    step();
    din_valid = 1'b0;
    lat = 1;
    while (dout_valid !== 1'b1 && lat < 300) begin
      if (swap_at > 0 && (lat == swap_at || lat == swap_at + 3)) cswap = 1'b1;
      step();
      cswap = 1'b0;
      lat++;
    end
    d0 = dout;
    got = int'($signed(dout));
    gch = int'(dout_ch);
    gsat = sat;
    bpre = bank_sel;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      step();
      if (dout_valid !== 1'b1 || dout !== d0 || dout_ch !== gch[0]
          || sat !== gsat || din_ready !== 1'b0) stable = 1'b0;
    end
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
  endtask

  task automatic b_send(input int c, input int xv, output int got,
                        output int gch, output bit gsat, output int lat);
    int n;
    n = 0;
    while (b_din_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    b_din = 16'(xv);
    b_din_ch = c[0];
    b_din_valid = 1'b1;
    step();
    b_din_valid = 1'b0;
    lat = 1;
    while (b_dout_valid !== 1'b1 && lat < 100) begin
      step();
      lat++;
    end
    got = int'($signed(b_dout));
    gch = int'(b_dout_ch);
    gsat = b_sat;
    b_dout_ready = 1'b1;
    step();
    b_dout_ready = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    bit seen;
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    checks++;
    if (din_ready !== 1'b0 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs got rdy=%b vld=%b want 0 0", din_ready, dout_valid);
    end
    checks++;
    if (dout !== 16'd0 || sat !== 1'b0 || bank_sel !== 1'b0 || dout_ch !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs got dout=%h sat=%b bank=%b ch=%b want zeros",
               dout, sat, bank_sel, dout_ch);
    end
    n = 0;
    seen = 1'b0;
    while (din_ready !== 1'b1 && n < 1000) begin
      if (dout_valid !== 1'b0) seen = 1'b1;
      step();
      n++;
    end
    checks++;
    if (n !== 128) begin
      errors++;
      $display("FAIL clr_len got %0d want 128", n);
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL clr_valid got dout_valid=1 want 0");
    end
  endtask

  task automatic test_impulse();
    int got, gch, lat, exp;
    bit gsat, es, bp, st;
    load_shadow(0, 1'b1);
    swap_idle();
    checks++;
    if (bank_sel !== m_bsel) begin
      errors++;
      $display("FAIL swap_idle got %b want %b", bank_sel, m_bsel);
    end
    for (int i = 0; i < 65; i++) begin
      hist[0].push_back(i == 0 ? 1 : 0);
      exp = clip(fir_sum(0), 0, es);
      send(0, i == 0 ? 1 : 0, -1, 0, got, gch, gsat, lat, bp, st);
      checks++;
      if (got !== exp || gsat !== es || gch !== 0) begin
        errors++;
        $display("FAIL impulse[%0d] got %0d sat=%b ch=%0d want %0d sat=%b ch=0",
                 i, got, gsat, gch, exp, es);
      end
      checks++;
      if (lat !== 66) begin
        errors++;
        $display("FAIL latency[%0d] got %0d want 66", i, lat);
      end
    end
  endtask

  task automatic test_interleave();
    int got, gch, lat, exp, c, xv;
    bit gsat, es, bp, st;
    for (int i = 0; i < 22; i++) begin
      if (i < 12) begin
        c = i % 2;
        xv = (c == 1) ? 100 : ((i == 0) ? 1 : 0);
      end else begin
        c = int'($urandom_range(0, 1));
        xv = int'($urandom_range(0, 2000)) - 1000;
      end
      hist[c].push_back(xv);
      exp = clip(fir_sum(c), 0, es);
      send(c, xv, -1, 0, got, gch, gsat, lat, bp, st);
      checks++;
      if (got !== exp || gsat !== es || gch !== c) begin
        errors++;
        $display("FAIL interleave[%0d] got %0d sat=%b ch=%0d want %0d sat=%b ch=%0d",
                 i, got, gsat, gch, exp, es, c);
      end
    end
  endtask

  task automatic test_saturate();
    int got, gch, lat, exp, xv;
    bit gsat, es, bp, st;
    load_shadow(32767, 1'b0);
    swap_idle();
    for (int i = 0; i < 10; i++) begin
      xv = (i < 2) ? 32767 : -32768;
      hist[0].push_back(xv);
      exp = clip(fir_sum(0), 0, es);
      send(0, xv, -1, 0, got, gch, gsat, lat, bp, st);
      checks++;
      if (got !== exp || gsat !== es) begin
        errors++;
        $display("FAIL sat_model[%0d] got %0d sat=%b want %0d sat=%b",
                 i, got, gsat, exp, es);
      end
      if (i == 1 || i == 9) begin
        checks++;
        if (got !== xv || gsat !== 1'b1) begin
          errors++;
          $display("FAIL sat_clip[%0d] got %0d sat=%b want %0d sat=1",
                   i, got, gsat, xv);
        end
      end
    end
  endtask

  task automatic test_swap_pending();
    int got, gch, lat, exp;
    bit gsat, es, bp, st, old;
    load_shadow(1, 1'b0);
    swap_idle();
    load_shadow(2, 1'b0);
    old = m_bsel;
    hist[1].push_back(7);
    exp = clip(fir_sum(1), 0, es);
    send(1, 7, 10, 0, got, gch, gsat, lat, bp, st);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL swap_old_bank got %0d want %0d", got, exp);
    end
    checks++;
    if (bp !== old) begin
      errors++;
      $display("FAIL swap_before_accept got %b want %b", bp, old);
    end
    m_bsel = !m_bsel;
    checks++;
    if (bank_sel !== m_bsel) begin
      errors++;
      $display("FAIL swap_on_accept got %b want %b", bank_sel, m_bsel);
    end
    hist[1].push_back(-9);
    exp = clip(fir_sum(1), 0, es);
    send(1, -9, -1, 0, got, gch, gsat, lat, bp, st);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL swap_new_bank got %0d want %0d", got, exp);
    end
  endtask

  task automatic test_hold_reset();
    int got, gch, lat, exp, n;
    bit gsat, es, bp, st, seen;
    hist[0].push_back(1234);
    exp = clip(fir_sum(0), 0, es);
    send(0, 1234, -1, 20, got, gch, gsat, lat, bp, st);
    checks++;
    if (got !== exp || st !== 1'b1) begin
      errors++;
      $display("FAIL hold got %0d stable=%b want %0d stable=1", got, st, exp);
    end
    n = 0;
    while (din_ready !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    din = 16'd555;
    din_ch = 1'b1;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    checks++;
    if (dout_valid !== 1'b0 || din_ready !== 1'b0 || bank_sel !== 1'b0) begin
      errors++;
      $display("FAIL abort got vld=%b rdy=%b bank=%b want 0 0 0",
               dout_valid, din_ready, bank_sel);
    end
    n = 0;
    seen = 1'b0;
    while (din_ready !== 1'b1 && n < 1000) begin
      if (dout_valid !== 1'b0) seen = 1'b1;
      step();
      n++;
    end
    checks++;
    if (n !== 128 || seen) begin
      errors++;
      $display("FAIL reclr got %0d cycles valid_seen=%b want 128 0", n, seen);
    end
    cload = 1'b1;
    caddr = 6'd0;
    cin = 16'd7;
    cswap = 1'b1;
    cm[m_bsel ? 0 : 1][0] = 7;
    m_bsel = !m_bsel;
    step();
    cload = 1'b0;
    cswap = 1'b0;
    checks++;
    if (bank_sel !== m_bsel) begin
      errors++;
      $display("FAIL load_swap_bank got %b want %b", bank_sel, m_bsel);
    end
    hist[1].push_back(5);
    exp = clip(fir_sum(1), 0, es);
    send(1, 5, -1, 0, got, gch, gsat, lat, bp, st);
    checks++;
    if (got !== exp || got !== 35 || gch !== 1) begin
      errors++;
      $display("FAIL post_reset got %0d ch=%0d want %0d (35) ch=1", got, gch, exp);
    end
  endtask

  task automatic test_round();
    int got, gch, lat, exp, c, xv;
    bit gsat, es;
    longint s;
    for (int j = 0; j < 8; j++) begin
      c2[j] = int'($urandom_range(0, 32767)) - 16384;
      b_cload = 1'b1;
      b_caddr = 3'(j);
      b_cin = 16'(c2[j]);
      step();
    end
    b_cload = 1'b0;
    b_cswap = 1'b1;
    step();
    b_cswap = 1'b0;
    checks++;
    if (b_bank_sel !== 1'b1) begin
      errors++;
      $display("FAIL round_swap got %b want 1", b_bank_sel);
    end
    for (int i = 0; i < 30; i++) begin
      c = int'($urandom_range(0, 1));
      xv = int'($urandom_range(0, 65535)) - 32768;
      hist2[c].push_back(xv);
      s = 0;
      for (int j = 0; j < 8; j++) begin
        if (j < hist2[c].size())
          s += longint'(hist2[c][hist2[c].size()-1-j]) * longint'(c2[j]);
      end
      exp = clip(s, 15, es);
      b_send(c, xv, got, gch, gsat, lat);
      checks++;
      if (got !== exp || gsat !== es || gch !== c || lat !== 10) begin
        errors++;
        $display("FAIL round[%0d] got %0d sat=%b ch=%0d lat=%0d want %0d sat=%b ch=%0d lat=10",
                 i, got, gsat, gch, lat, exp, es, c);
      end
    end
  endtask

  initial begin
    repeat (3) step();
    rst = 1'b0;
    test_reset();
    test_impulse();
    test_interleave();
    test_saturate();
    test_swap_pending();
    test_hold_reset();
    test_round();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
